// File: rtl/cache_types.sv
// Shared types for the cache <-> physical-memory line adaptor.
// A 256-bit cache line moves as four 64-bit beats, lowest beat first.
package cache_types;

    localparam int CLA_BEATS       = 4;
    localparam int CLA_LINE_OFFSET = 5;

    typedef logic [255:0] llc_cacheline;
    typedef logic [63:0]  cla_beat_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } cla_state_t;

    // Clear the byte-within-line offset so the burst starts on a line boundary.
    function automatic logic [31:0] cla_line_addr(input logic [31:0] addr);
        return addr & ~((32'd1 << CLA_LINE_OFFSET) - 32'd1);
    endfunction

endpackage

// File: rtl/cla_line_buffer.sv
// One-line staging register for the adaptor: full-line load for writes,
// beat-indexed fill for reads, beat-indexed read port for write bursts.
module cla_line_buffer
    import cache_types::*;
#(
    parameter int BEATS = CLA_BEATS,
    parameter int IDX_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  llc_cacheline     load_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  cla_beat_t        wr_beat,
    input  logic [IDX_W-1:0] rd_idx,
    output cla_beat_t        rd_beat,
    output llc_cacheline     line
);

    // Line storage: a full load takes priority over a single-beat fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line <= '0;
        end else if (load_en) begin
            line <= load_line;
        end else if (wr_en) begin
            line[64*wr_idx +: 64] <= wr_beat;
        end
    end

    assign rd_beat = line[64*rd_idx +: 64];

endmodule

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: turns one 256-bit line request from the cache into a
// 4 x 64-bit burst on the memory bus and returns a one-cycle resp_o.
// Optional feature: define CLA_TIMEOUT_EN to add a beat-gap watchdog that
// forces completion and raises a sticky error_o (parameter TIMEOUT_CYCLES).
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int BEATS = CLA_BEATS
`ifdef CLA_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    input  llc_cacheline line_i,
    output llc_cacheline line_o,
    output logic         resp_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output cla_beat_t    burst_o,
    input  cla_beat_t    burst_i,
    input  logic         resp_i
`ifdef CLA_TIMEOUT_EN
    ,
    output logic         error_o
`endif
);

    localparam int              CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    cla_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             skip_req;
    logic             buf_load;
    logic             buf_wr;
    logic [CNT_W-1:0] rd_idx;
    cla_beat_t        rd_beat;
    logic             timed_out;

    // A write launch snapshots the whole line; read beats land at cnt.
    assign buf_load = (state == IDLE) && !skip_req && write_i && !read_i;
    assign buf_wr   = (state == RD_BURST) && resp_i;
    // Look one beat ahead so burst_o is ready the cycle after a beat is accepted.
    assign rd_idx   = cnt + CNT_W'(1);

    cla_line_buffer #(
        .BEATS (BEATS),
        .IDX_W (CNT_W)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load_en   (buf_load),
        .load_line (line_i),
        .wr_en     (buf_wr),
        .wr_idx    (cnt),
        .wr_beat   (burst_i),
        .rd_idx    (rd_idx),
        .rd_beat   (rd_beat),
        .line      (line_o)
    );

`ifdef CLA_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] wait_cnt;
    logic              in_burst;

    assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
    assign timed_out = in_burst && !resp_i && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts idle burst cycles since the last beat; error is sticky.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
            error_o  <= 1'b0;
        end else begin
            if ((state == IDLE) || resp_i) begin
                wait_cnt <= '0;
            end else if (in_burst) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (timed_out) begin
                error_o <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Control FSM with registered bus outputs; resp_o is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            skip_req  <= 1'b0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            address_o <= '0;
            burst_o   <= '0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The cache still holds its request in the cycle after resp_o;
                    // ignore that one cycle so the same request is not re-run.
                    if (skip_req) begin
                        skip_req <= 1'b0;
                    end else if (read_i) begin
                        address_o <= cla_line_addr(address_i);
                        cnt       <= '0;
                        read_o    <= 1'b1;
                        state     <= RD_BURST;
                    end else if (write_i) begin
                        address_o <= cla_line_addr(address_i);
                        cnt       <= '0;
                        write_o   <= 1'b1;
                        burst_o   <= line_i[63:0];
                        state     <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        if (cnt == LAST_BEAT) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= RD_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (timed_out) begin
                        read_o <= 1'b0;
                        resp_o <= 1'b1;
                        state  <= RD_DONE;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        if (cnt == LAST_BEAT) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= WR_DONE;
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            burst_o <= rd_beat;
                        end
                    end else if (timed_out) begin
                        write_o <= 1'b0;
                        resp_o  <= 1'b1;
                        state   <= WR_DONE;
                    end
                end
                RD_DONE, WR_DONE: begin
                    skip_req <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: a responding memory model drives beats, and
// expected lines/beats are queued at request time and popped on completion.
module tb_cacheline_adaptor;
  import cache_types::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  llc_cacheline line_i = '0;
  llc_cacheline line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  cla_beat_t    burst_o;
  cla_beat_t    burst_i = '0;
  logic         resp_i = 1'b0;
`ifdef CLA_TIMEOUT_EN
  logic         error_o;
`endif

  int n_pass = 0;
  int n_checks = 0;

  llc_cacheline exp_lines[$];
  cla_beat_t    exp_beats[$];

  always #5 clk = ~clk;

`ifdef CLA_TIMEOUT_EN
  cacheline_adaptor #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i),
    .error_o   (error_o)
  );
`else
  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );
`endif

  // Memory side of a read: beats returned after 'gap' idle cycles each, only
  // the first n_beats are ever sent. Observations are returned to the caller.
  task automatic run_read(input logic [31:0] addr, input cla_beat_t beats[4], input int gap,
                          input int n_beats, input bit also_write, input bit hold,
                          output int rd_cycles, output int resp_cnt, output llc_cacheline resp_line,
                          output bit wr_seen, output logic [31:0] addr_seen, output int lat,
                          output bit post_busy, output bit tmo, output int beat_to_resp);
    int e, k, g, post, last_e;
    bit got;
    rd_cycles = 0; resp_cnt = 0; resp_line = '0; wr_seen = 0; addr_seen = '0;
    lat = 0; post_busy = 0; tmo = 0; beat_to_resp = 0;
    e = 0; k = 0; g = 0; post = 0; last_e = 0; got = 0;
    exp_lines.push_back({beats[3], beats[2], beats[1], beats[0]});
    address_i = addr;
    read_i    = 1'b1;
    write_i   = also_write;
    line_i    = {8{$urandom}};
    while (1) begin
      @(posedge clk); #1; e++;
      if (read_o) begin rd_cycles++; addr_seen = address_o; end
      if (write_o) wr_seen = 1;
      if (resp_o) resp_cnt++;
      if (got) begin
        if (read_o || write_o) post_busy = 1;
        post++;
        if (post == 2) begin read_i = 1'b0; write_i = 1'b0; end
        if (post == 3) break;
      end else if (resp_o) begin
        got = 1;
        resp_line = line_o;
        lat = e + 1;  // counts the request cycle itself
        beat_to_resp = e - last_e;
        if (!hold) begin read_i = 1'b0; write_i = 1'b0; end
      end
      resp_i  = 1'b0;
      burst_i = {$urandom, $urandom};
      if (read_o && k < n_beats) begin
        if (g < gap) g++;
        else begin resp_i = 1'b1; burst_i = beats[k]; k++; g = 0; last_e = e + 1; end
      end
      if (e > 200) begin tmo = 1; break; end
    end
    resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
  endtask

  // Memory side of a write: captures burst_o at every beat it accepts.
  task automatic run_write(input logic [31:0] addr, input llc_cacheline line, input int gap,
                           output cla_beat_t seen[4], output int wr_cycles, output int resp_cnt,
                           output logic wr_at_resp, output logic wr_before, output bit tmo);
    int e, k, g, post;
    bit got;
    logic prev_wr;
    for (int i = 0; i < 4; i++) begin seen[i] = '0; exp_beats.push_back(line[64*i +: 64]); end
    wr_cycles = 0; resp_cnt = 0; wr_at_resp = 1'bx; wr_before = 1'bx; tmo = 0;
    e = 0; k = 0; g = 0; post = 0; got = 0; prev_wr = 1'b0;
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    while (1) begin
      @(posedge clk); #1; e++;
      if (write_o) wr_cycles++;
      if (resp_o) resp_cnt++;
      if (got) begin
        post++;
        if (post == 3) break;
      end else if (resp_o) begin
        got = 1; wr_at_resp = write_o; wr_before = prev_wr; write_i = 1'b0;
      end
      prev_wr = write_o;
      resp_i  = 1'b0;
      burst_i = {$urandom, $urandom};
      if (write_o && k < 4) begin
        if (g < gap) g++;
        else begin resp_i = 1'b1; seen[k] = burst_o; k++; g = 0; end
      end
      if (e > 200) begin tmo = 1; break; end
    end
    resp_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1; line_i = {8{32'hDEADBEEF}};
    repeat (2) @(posedge clk);
    #1;
    if (read_o !== 1'b0) $display("FAIL reset_read_o: got %b need 0", read_o); else n_pass++; n_checks++;
    if (write_o !== 1'b0) $display("FAIL reset_write_o: got %b need 0", write_o); else n_pass++; n_checks++;
    if (resp_o !== 1'b0) $display("FAIL reset_resp_o: got %b need 0", resp_o); else n_pass++; n_checks++;
    if (address_o !== 32'h0) $display("FAIL reset_address_o: got %h need 0", address_o); else n_pass++; n_checks++;
    if (burst_o !== 64'h0) $display("FAIL reset_burst_o: got %h need 0", burst_o); else n_pass++; n_checks++;
    if (line_o !== 256'h0) $display("FAIL reset_line_o: got %h need 0", line_o); else n_pass++; n_checks++;
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    cla_beat_t b[4];
    int rc, pc, lat, btr; llc_cacheline ln; bit ws, pb, tmo; logic [31:0] as;
    b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
    b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
    run_read(32'h1234_5678, b, 0, 4, 0, 0, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (tmo !== 1'b0) $display("FAIL read_bound: no resp_o within budget"); else n_pass++; n_checks++;
    if (rc !== 4) $display("FAIL read_o_cycles: got %0d need 4", rc); else n_pass++; n_checks++;
    if (pc !== 1) $display("FAIL read_resp_pulses: got %0d need 1", pc); else n_pass++; n_checks++;
    if (ln !== exp_lines.pop_front())
      $display("FAIL read_line: got %h need %h", ln, 256'h4444444444444444333333333333333322222222222222221111111111111111);
    else n_pass++;
    n_checks++;
    if (as !== 32'h1234_5660) $display("FAIL read_address: got %h need 12345660", as); else n_pass++; n_checks++;
    if (lat !== 6) $display("FAIL read_latency: got %0d need 6", lat); else n_pass++; n_checks++;
    if (ws !== 1'b0) $display("FAIL read_no_write: got %b need 0", ws); else n_pass++; n_checks++;
    if (line_o !== ln) $display("FAIL read_line_hold: got %h need %h", line_o, ln); else n_pass++; n_checks++;
  endtask

  task automatic test_write();
    llc_cacheline wl, want;
    cla_beat_t seen[4];
    int wc, pc; logic war, wbf; bit tmo;
    for (int i = 0; i < 32; i++) wl[8*i +: 8] = 8'(i * 8);
    run_write(32'hABCD_EF3F, wl, 0, seen, wc, pc, war, wbf, tmo);
    if (tmo !== 1'b0) $display("FAIL write_bound: no resp_o within budget"); else n_pass++; n_checks++;
    for (int i = 0; i < 4; i++) begin
      want[63:0] = exp_beats.pop_front();
      if (seen[i] !== want[63:0]) $display("FAIL write_beat%0d: got %h need %h", i, seen[i], want[63:0]);
      else n_pass++;
      n_checks++;
    end
    if (wc !== 4) $display("FAIL write_o_cycles: got %0d need 4", wc); else n_pass++; n_checks++;
    if (pc !== 1) $display("FAIL write_resp_pulses: got %0d need 1", pc); else n_pass++; n_checks++;
    if (war !== 1'b0 || wbf !== 1'b1)
      $display("FAIL write_o_drop: at resp %b before %b need 0 and 1", war, wbf);
    else n_pass++;
    n_checks++;
    if (line_o !== wl) $display("FAIL write_line_held: got %h need %h", line_o, wl); else n_pass++; n_checks++;
    for (int i = 0; i < 8; i++) wl[32*i +: 32] = $urandom;
    run_write(32'h0000_1000, wl, 2, seen, wc, pc, war, wbf, tmo);
    for (int i = 0; i < 4; i++) begin
      want[63:0] = exp_beats.pop_front();
      if (seen[i] !== want[63:0]) $display("FAIL write_gap_beat%0d: got %h need %h", i, seen[i], want[63:0]);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_read_gaps();
    cla_beat_t b[4];
    int rc, pc, lat, btr; llc_cacheline ln; bit ws, pb, tmo; logic [31:0] as;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    run_read(32'h8000_0020, b, 3, 4, 0, 0, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (tmo !== 1'b0) $display("FAIL gaps_bound: no resp_o within budget"); else n_pass++; n_checks++;
    if (ln !== exp_lines.pop_front()) $display("FAIL gaps_line: got %h need %h", ln, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    if (pc !== 1) $display("FAIL gaps_resp_pulses: got %0d need 1", pc); else n_pass++; n_checks++;
    if (rc !== 16) $display("FAIL gaps_read_o_cycles: got %0d need 16", rc); else n_pass++; n_checks++;
    if (lat !== 18) $display("FAIL gaps_latency: got %0d need 18", lat); else n_pass++; n_checks++;
  endtask

  task automatic test_both_high();
    cla_beat_t b[4];
    int rc, pc, lat, btr; llc_cacheline ln; bit ws, pb, tmo; logic [31:0] as;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    run_read(32'h0000_0440, b, 0, 4, 1, 0, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (ws !== 1'b0) $display("FAIL both_write_o: got %b need 0", ws); else n_pass++; n_checks++;
    if (ln !== exp_lines.pop_front()) $display("FAIL both_line: got %h need %h", ln, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    if (pc !== 1) $display("FAIL both_resp_pulses: got %0d need 1", pc); else n_pass++; n_checks++;
  endtask

  task automatic test_reset_mid_burst();
    cla_beat_t b[4];
    int k, pulses, rc, pc, lat, btr; llc_cacheline ln; bit fired, ws, pb, tmo; logic [31:0] as;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    k = 0; fired = 0; pulses = 0;
    address_i = 32'h5555_0000; read_i = 1'b1;
    for (int e = 0; e < 20 && !fired; e++) begin
      @(posedge clk); #1;
      resp_i = 1'b0;
      if (read_o) begin
        resp_i = 1'b1; burst_i = b[k];
        if (k == 2) begin rst = 1'b0; fired = 1; end
        k++;
      end
    end
    if (!fired) $display("FAIL midrst_bound: burst never reached beat 2"); else n_pass++; n_checks++;
    @(posedge clk); #1;
    if (read_o !== 1'b0) $display("FAIL midrst_read_o: got %b need 0", read_o); else n_pass++; n_checks++;
    if (line_o !== 256'h0) $display("FAIL midrst_line_o: got %h need 0", line_o); else n_pass++; n_checks++;
    if (resp_o) pulses++;
    rst = 1'b1; read_i = 1'b0; resp_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (resp_o) pulses++; end
    if (pulses !== 0) $display("FAIL midrst_no_resp: got %0d pulses need 0", pulses); else n_pass++; n_checks++;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    run_read(32'h5555_0000, b, 0, 4, 0, 0, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (ln !== exp_lines.pop_front()) $display("FAIL midrst_next_line: got %h need %h", ln, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    if (pc !== 1) $display("FAIL midrst_next_resp: got %0d need 1", pc); else n_pass++; n_checks++;
  endtask

  task automatic test_back_to_back();
    cla_beat_t b[4];
    cla_beat_t seen[4];
    llc_cacheline wl, want;
    int rc, pc, lat, btr, wc; llc_cacheline ln; bit ws, pb, tmo; logic [31:0] as; logic war, wbf;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    run_read(32'h0F00_0000, b, 0, 4, 0, 1, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (pb !== 1'b0) $display("FAIL b2b_relaunch: got busy %b need 0", pb); else n_pass++; n_checks++;
    if (ln !== exp_lines.pop_front()) $display("FAIL b2b_line0: got %h need %h", ln, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 8; i++) wl[32*i +: 32] = $urandom;
    run_write(32'h0F00_0040, wl, 0, seen, wc, pc, war, wbf, tmo);
    for (int i = 0; i < 4; i++) begin
      want[63:0] = exp_beats.pop_front();
      if (seen[i] !== want[63:0]) $display("FAIL b2b_wbeat%0d: got %h need %h", i, seen[i], want[63:0]);
      else n_pass++;
      n_checks++;
    end
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    run_read(32'h0F00_0080, b, 1, 4, 0, 0, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (ln !== exp_lines.pop_front()) $display("FAIL b2b_line1: got %h need %h", ln, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    if (as !== 32'h0F00_0080) $display("FAIL b2b_address: got %h need 0f000080", as); else n_pass++; n_checks++;
  endtask

`ifdef CLA_TIMEOUT_EN
  task automatic test_timeout();
    cla_beat_t b[4];
    int rc, pc, lat, btr; llc_cacheline ln; bit ws, pb, tmo; logic [31:0] as;
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
    b[0] = {$urandom, $urandom}; b[1] = {$urandom, $urandom}; b[2] = '0; b[3] = '0;
    run_read(32'h2000_0000, b, 0, 2, 0, 0, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (tmo !== 1'b0) $display("FAIL tmo_bound: no resp_o within budget"); else n_pass++; n_checks++;
    if (btr !== 16) $display("FAIL tmo_delay: got %0d need 16", btr); else n_pass++; n_checks++;
    if (error_o !== 1'b1) $display("FAIL tmo_error: got %b need 1", error_o); else n_pass++; n_checks++;
    if (ln !== exp_lines.pop_front()) $display("FAIL tmo_partial_line: got %h need %h", ln, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    run_read(32'h2000_0100, b, 0, 4, 0, 0, rc, pc, ln, ws, as, lat, pb, tmo, btr);
    if (ln !== exp_lines.pop_front()) $display("FAIL tmo_next_line: got %h need %h", ln, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    if (error_o !== 1'b1) $display("FAIL tmo_sticky: got %b need 1", error_o); else n_pass++; n_checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_read_gaps();
    test_both_high();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef CLA_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
